prefetch_buffer: RTL and testbench

PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/prefetch_fifo.sv | 51 +++++
 rtl/prefetch_buffer.sv | 178 +++++++++++++++++
 tb/tb_prefetch_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline constants and types: NOP encoding, datapath width, reset PC
// and the prefetch FSM encoding.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StHold
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Power-of-two circular FIFO holding fetched {instr, pc} entries; a push is
// accepted while full only when a pop happens in the same cycle.
module prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: credit-limited fetch, in-order response FIFO, redirect
// flush with stale-response discard. PREFETCH_PERF_EN adds saturating perf counters.
module prefetch_buffer
  import pipeline_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_empty
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   stale_q, stale_d;
  logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;
  logic            valid_q, valid_d;

  logic            accept, rsp_ok, rsp_stale, rsp_live, bypass;
  logic            fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count, count_next;
  logic [CW:0]     credit_sum;
  logic            credit_ok;
  fetch_entry_t    fifo_wdata, fifo_rdata;

  prefetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(2 * XLEN)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(fifo_flush),
    .push (fifo_push),
    .wdata(fifo_wdata),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = fetch_pc_q;

  always_comb begin
    accept    = imem_req && imem_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_ok    = imem_rvalid && (outstanding_q != '0);
    rsp_stale = rsp_ok && (stale_q != '0);
    rsp_live  = rsp_ok && (stale_q == '0) && !PCSrcE;
    // Empty FIFO and free decode: forward the response straight to the outputs.
    bypass    = rsp_live && fifo_empty && !StallD;
    fifo_pop  = !PCSrcE && !StallD && !fifo_empty;
    fifo_push = rsp_live && !bypass && (!fifo_full || fifo_pop);
    fifo_flush = PCSrcE;
    fifo_wdata = '{instr: imem_rdata, pc: resp_pc_q};

    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_ok);
    // Everything still in flight after a redirect, including a request accepted
    // in the redirect cycle itself, belongs to the old path.
    stale_d = PCSrcE ? outstanding_d : stale_q - CW'(rsp_stale);

    fetch_pc_d = fetch_pc_q;
    if (PCSrcE)      fetch_pc_d = PCTargetE;
    else if (accept) fetch_pc_d = pc_plus4(fetch_pc_q);

    resp_pc_d = resp_pc_q;
    if (PCSrcE)        resp_pc_d = PCTargetE;
    else if (rsp_live) resp_pc_d = pc_plus4(resp_pc_q);

    count_next = PCSrcE ? '0 : fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    credit_sum = (CW + 1)'(outstanding_d) + (CW + 1)'(count_next);
    credit_ok  = credit_sum < (CW + 1)'(DEPTH);
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (PCSrcE) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!StallD) begin
      if (fifo_pop) begin
        instr_d = fifo_rdata.instr;
        pc_d    = fifo_rdata.pc;
        pc4_d   = pc_plus4(fifo_rdata.pc);
        valid_d = 1'b1;
      end else if (bypass) begin
        instr_d = imem_rdata;
        pc_d    = resp_pc_q;
        pc4_d   = pc_plus4(resp_pc_q);
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:          state_d = StFetch;
      StFetch, StHold: state_d = credit_ok ? StFetch : StHold;
      default:         state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
      instr_q       <= NOP_INSTR;
      pc_q          <= '0;
      pc4_q         <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      pc4_q         <= pc4_d;
      valid_q       <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pc_q;
  assign PCPlus4D = pc4_q;
  assign ValidD   = valid_q;

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_redirects_q, perf_empty_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_redirects_q <= '0;
      perf_empty_q     <= '0;
    end else begin
      if (PCSrcE && (perf_redirects_q != '1)) perf_redirects_q <= perf_redirects_q + 32'd1;
      if (!StallD && fifo_empty && (perf_empty_q != '1)) perf_empty_q <= perf_empty_q + 32'd1;
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_empty     = perf_empty_q;
`endif

endmodule

// File: tb/tb_prefetch_buffer.sv
// Self-checking bench for prefetch_buffer: directed scenarios then randomized traffic
// against an in-order memory model and a program-order PC stream reference.
module tb_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, rst, PCSrcE, StallD, imem_ready, imem_rvalid;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_redirects, perf_empty;
`endif

  prefetch_buffer #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE),
    .StallD(StallD),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .InstrD(InstrD),
    .PCD(PCD),
    .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_redirects(perf_redirects),
    .perf_empty(perf_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] acc_log[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          inj_err = 1'b0;
  logic [31:0] exp_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: present memory response, log acceptance, advance, then check.
  task automatic cycle(input bit chk);
    logic [31:0] s_instr, s_pc, s_pc4, s_tgt;
    logic        s_valid;
    bit          s_red, s_stall;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else if (pend.size() == 0 && inj_err && $urandom_range(0, 31) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    if (imem_req && imem_ready) begin
      pend.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
      acc_log.push_back(imem_addr);
    end
    s_instr = InstrD; s_pc = PCD; s_pc4 = PCPlus4D; s_valid = ValidD;
    s_red = PCSrcE; s_stall = StallD; s_tgt = PCTargetE;
    @(posedge clk);
    #1;
    cyc++;
    if (chk) begin
      if (s_red) begin
        check("redirect_nop", InstrD, NOP);
        check("redirect_valid", {31'b0, ValidD}, 32'd0);
        exp_pc = s_tgt;
      end else if (s_stall) begin
        check("stall_hold_instr", InstrD, s_instr);
        check("stall_hold_pc", PCD, s_pc);
        check("stall_hold_pc4", PCPlus4D, s_pc4);
        check("stall_hold_valid", {31'b0, ValidD}, {31'b0, s_valid});
      end else if (ValidD) begin
        check("stream_pc", PCD, exp_pc);
        check("stream_instr", InstrD, mem_word(exp_pc));
        check("stream_pc4", PCPlus4D, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end else begin
        check("empty_nop", InstrD, NOP);
        check("empty_pc_hold", PCD, s_pc);
        check("empty_pc4_hold", PCPlus4D, s_pc4);
      end
      check("credit_bound", {31'b0, pend.size() <= DEPTH}, 32'd1);
    end
  endtask

  task automatic check_reset_values();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_instr", InstrD, NOP);
    check("rst_pcd", PCD, 32'd0);
    check("rst_pc4", PCPlus4D, 32'd0);
    check("rst_valid", {31'b0, ValidD}, 32'd0);
  endtask

  initial begin
    bit seen;
    logic [31:0] a0;
    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // Reset and the first fetch stream.
    cycle(0);
    cycle(0);
    check_reset_values();
    pend.delete(); acc_log.delete(); exp_pc = RESET_PC;
    rst = 1'b1;
    cycle(1);
    cycle(1);
    check("first_valid_latency", {31'b0, ValidD}, 32'd0);
    cycle(1);
    check("first_valid", {31'b0, ValidD}, 32'd1);
    check("first_pcd", PCD, 32'h0);
    check("first_pc4", PCPlus4D, 32'h4);
    repeat (3) cycle(1);
    check("addr_seq_len", {31'b0, acc_log.size() >= 4}, 32'd1);
    for (int k = 0; k < 4; k++) check("addr_seq", acc_log[k], 32'(4 * k));

    // Long stall: FIFO fills, fetch stops, then resumes gap-free.
    StallD = 1'b1;
    repeat (10) cycle(1);
    check("stall_hold_req", {31'b0, imem_req}, 32'd0);
    check("stall_no_outstanding", pend.size(), 32'd0);
    StallD = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle(1);
      check("resume_no_gap", {31'b0, ValidD}, 32'd1);
    end

    // Memory back-pressure: request held stable, no duplicate fetch.
    imem_ready = 1'b0;
    a0 = imem_addr;
    for (int k = 0; k < 5; k++) begin
      check("bp_req_high", {31'b0, imem_req}, 32'd1);
      check("bp_addr_stable", imem_addr, a0);
      cycle(1);
    end
    check("bp_drained_nop", {31'b0, ValidD}, 32'd0);
    imem_ready = 1'b1;
    repeat (5) cycle(1);

    // Redirect with three requests in flight.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && pend.size() != 3; k++) cycle(1);
    check("three_outstanding", pend.size(), 32'd3);
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
    cycle(1);
    PCSrcE = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (imem_req && imem_ready) seen = 1'b1;
      else cycle(1);
    end
    check("redir_req_seen", {31'b0, seen}, 32'd1);
    check("redir_first_addr", imem_addr, 32'h0000_0100);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      cycle(1);
      if (ValidD) seen = 1'b1;
    end
    check("redir_valid_seen", {31'b0, seen}, 32'd1);
    check("redir_first_pcd", PCD, 32'h0000_0100);

    // Redirect wins over a simultaneous stall.
    lat_min = 1; lat_max = 1;
    repeat (4) cycle(1);
    StallD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
    cycle(1);
    check("redir_stall_instr", InstrD, NOP);
    check("redir_stall_valid", {31'b0, ValidD}, 32'd0);
    PCSrcE = 1'b0; StallD = 1'b0;
    repeat (10) cycle(1);

    // Randomized traffic with spurious responses.
    lat_min = 1; lat_max = 4; inj_err = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      imem_ready = ($urandom_range(0, 3) != 0);
      StallD     = ($urandom_range(0, 9) < 3);
      PCSrcE     = ($urandom_range(0, 24) == 0);
      PCTargetE  = 32'h0000_1000 + ($urandom_range(0, 255) << 2);
      cycle(1);
    end
    PCSrcE = 1'b0; StallD = 1'b0; imem_ready = 1'b1; inj_err = 1'b0;
    repeat (20) cycle(1);

    // Reset mid-stream.
    rst = 1'b0;
    cycle(0);
    check_reset_values();
    pend.delete(); acc_log.delete(); exp_pc = RESET_PC;
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      if (imem_req && imem_ready) seen = 1'b1;
      else cycle(1);
    end
    check("rst_refetch_seen", {31'b0, seen}, 32'd1);
    check("rst_refetch_addr", imem_addr, RESET_PC);
    repeat (20) cycle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
